// File: rtl/sm_hex_scan.sv
// Multiplexed seven-segment scanner: one shared segment bus, one anode per digit,
// inputs snapshotted once per frame so a displayed value never tears mid-scan.
module sm_hex_scan #(
    parameter int DIGITS           = 8,
    parameter int TICK             = 50000,
    parameter int BLANK_CYCLES     = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frame
);

    localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK - 1);
    localparam logic [CW-1:0] CNT_ARM  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   num_q, num_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic [DIGITS-1:0]     en_q, en_d;
    logic                  lz_q, lz_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dot_q, dot_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  slot_end, frame_edge, blank;
    logic [IW-1:0]         idx_nxt;
    logic [4*DIGITS-1:0]   src_num;
    logic [DIGITS-1:0]     src_dp, src_en, zero_above, sel_nxt, sel_cur;
    logic                  src_lz, above;
    logic [3:0]            nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= CNT_LAST;
            idx_q   <= IDX_LAST;
            num_q   <= '0;
            dp_q    <= '0;
            en_q    <= '0;
            lz_q    <= 1'b0;
            seg_q   <= '0;
            dot_q   <= 1'b0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            lz_q    <= lz_d;
            seg_q   <= seg_d;
            dot_q   <= dot_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_edge = slot_end && (idx_q == IDX_LAST);
        idx_nxt    = frame_edge ? '0 : idx_q + 1'b1;

        // At the frame boundary the digit-0 glyph must come from the values being captured.
        src_num = frame_edge ? number   : num_q;
        src_dp  = frame_edge ? dp       : dp_q;
        src_en  = frame_edge ? digit_en : en_q;
        src_lz  = frame_edge ? lz_blank : lz_q;

        above      = 1'b1;
        zero_above = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above         = above && (src_num[4*i +: 4] == 4'h0);
            zero_above[i] = above;
        end

        nib     = src_num[4*int'(idx_nxt) +: 4];
        blank   = src_lz && (idx_nxt != '0) && zero_above[idx_nxt];
        sel_nxt = '0;
        sel_nxt[idx_nxt] = 1'b1;
        sel_cur = '0;
        sel_cur[idx_q] = 1'b1;

        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        num_d   = num_q;
        dp_d    = dp_q;
        en_d    = en_q;
        lz_d    = lz_q;
        seg_d   = seg_q;
        dot_d   = dot_q;
        an_d    = an_q;
        frame_d = 1'b0;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_nxt;
            seg_d = blank ? 7'b0000000 : glyph(nib);
            dot_d = src_dp[idx_nxt];
            an_d  = (BLANK_CYCLES == 0 && src_en[idx_nxt]) ? sel_nxt : '0;
            if (frame_edge) begin
                num_d   = number;
                dp_d    = dp;
                en_d    = digit_en;
                lz_d    = lz_blank;
                frame_d = 1'b1;
            end
        end else if (BLANK_CYCLES > 0 && cnt_q == CNT_ARM) begin
            an_d = en_q[idx_q] ? sel_cur : '0;
        end
    end

    always_comb begin
        seven_segments = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
        dot            = SEG_ACTIVE_LOW ? ~dot_q : dot_q;
        anodes         = ANODE_ACTIVE_LOW ? ~an_q : an_q;
        frame          = frame_q;
    end

endmodule
